// File: rtl/background_pkg.sv
// Shared command, frame geometry and fetch-state encodings
// for the background refresh path.
package background_pkg;

    localparam logic [1:0] BG_CMD_HOLD     = 2'd0;
    localparam logic [1:0] BG_CMD_NEXT     = 2'd1;
    localparam logic [1:0] BG_CMD_ROWSTART = 2'd2;

    localparam int BLOCKS_PER_ROW = 80;
    localparam int NUM_BLOCKS     = 4800;
    localparam int BLOCK_SIZE     = 8;

    localparam logic [1:0] FS_IDLE    = 2'd0;
    localparam logic [1:0] FS_ISSUE   = 2'd1;
    localparam logic [1:0] FS_WAIT    = 2'd2;
    localparam logic [1:0] FS_CAPTURE = 2'd3;

endpackage

// File: rtl/background_addr_unit_if.sv
// Background RAM read port: address and read strobe out,
// read data back.
interface background_addr_unit_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 9
);

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_data
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_data
    );

endinterface

// File: rtl/background_addr_unit_fetch_pipe.sv
// Follows one background read through the RAM latency so that
// only a response nobody has aborted reaches the capture stage.
module bg_fetch_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic shift_in,
    input  logic abort,
    output logic pre_o,
    output logic cap_o
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH:0]   chain;

    always_comb begin
        chain = {v_q, shift_in};
        v_d   = abort ? '0 : chain[DEPTH-1:0];
    end

    // pre_o is one stage before the data window, cap_o is the window
    assign pre_o = chain[DEPTH-1];
    assign cap_o = chain[DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

endmodule

// File: rtl/background_addr_unit.sv
// Background block address register, row tracking and block-word
// fetch from background RAM for the pixel-drawing path.
module background_addr_unit
    import background_pkg::*;
#(
    parameter int BLOCKS_PER_ROW = background_pkg::BLOCKS_PER_ROW,
    parameter int NUM_BLOCKS     = background_pkg::NUM_BLOCKS,
    parameter int ADDR_W         = 13,
    parameter int DATA_W         = 9,
    parameter int MEM_LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr_signal,
    input  logic                  en_refresh,
    input  logic                  reset_addr,
    background_addr_unit_if.master mem,
    output logic [DATA_W-1:0]     bg_data,
    output logic                  bg_valid,
    output logic                  row_done
);

    localparam int COL_W = $clog2(BLOCKS_PER_ROW + 1);
    localparam logic [COL_W-1:0] COL_END = COL_W'(BLOCKS_PER_ROW);
    localparam logic [ADDR_W:0] ROW_STEP = (ADDR_W + 1)'(BLOCKS_PER_ROW);
    localparam logic [ADDR_W:0] ADDR_END = (ADDR_W + 1)'(NUM_BLOCKS);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] row_start_q, row_start_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [1:0]        state_q, state_d;
    logic              live_q, live_d;
    logic              row_done_q, row_done_d;
    logic              bg_valid_q, bg_valid_d;
    logic [DATA_W-1:0] bg_data_q, bg_data_d;

    logic [ADDR_W:0] addr_inc;
    logic [ADDR_W:0] row_sum;
    logic [ADDR_W:0] row_next;
    logic            fetch_req;
    logic            addr_chg;
    logic            fire;
    logic            abort;
    logic            pre;
    logic            cap;

    // live_q holds the read strobe off for the cycle a clear is released
    assign fire  = (state_q == FS_ISSUE) && live_q;
    assign abort = fetch_req || addr_chg;

    always_comb begin
        addr_inc    = {1'b0, addr_q} + 1'b1;
        row_sum     = {1'b0, row_start_q} + ROW_STEP;
        row_next    = (row_sum >= ADDR_END) ? '0 : row_sum;
        addr_d      = addr_q;
        row_start_d = row_start_q;
        col_d       = col_q;
        fetch_req   = 1'b0;
        addr_chg    = 1'b0;
        live_d      = reset_addr;
        if (!reset_addr) begin
            addr_d      = '0;
            row_start_d = '0;
            col_d       = '0;
            fetch_req   = 1'b1;
        end else if (en_refresh && addr_signal == BG_CMD_NEXT) begin
            addr_chg = 1'b1;
            if (col_q < COL_END) begin
                addr_d    = addr_inc[ADDR_W-1:0];
                col_d     = col_q + 1'b1;
                fetch_req = (col_d < COL_END);
            end else begin
                addr_d      = row_next[ADDR_W-1:0];
                row_start_d = row_next[ADDR_W-1:0];
                col_d       = '0;
                fetch_req   = 1'b1;
            end
        end else if (en_refresh && addr_signal == BG_CMD_ROWSTART) begin
            addr_d    = row_start_q;
            col_d     = '0;
            addr_chg  = 1'b1;
            fetch_req = 1'b1;
        end
        row_done_d = (col_d == COL_END);
    end

    always_comb begin
        state_d    = state_q;
        bg_valid_d = bg_valid_q;
        bg_data_d  = bg_data_q;
        unique case (state_q)
            FS_ISSUE: begin
                if (fire) begin
                    state_d = pre ? FS_CAPTURE : FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (pre) begin
                    state_d = FS_CAPTURE;
                end
            end
            FS_CAPTURE: begin
                state_d = FS_IDLE;
                if (cap) begin
                    bg_data_d  = mem.mem_data;
                    bg_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
        // a new address always wins over a response in flight
        if (abort) begin
            bg_valid_d = 1'b0;
            bg_data_d  = bg_data_q;
            state_d    = fetch_req ? FS_ISSUE : FS_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q      <= '0;
            row_start_q <= '0;
            col_q       <= '0;
            state_q     <= FS_ISSUE;
            live_q      <= 1'b0;
            row_done_q  <= 1'b0;
            bg_valid_q  <= 1'b0;
            bg_data_q   <= '0;
        end else begin
            addr_q      <= addr_d;
            row_start_q <= row_start_d;
            col_q       <= col_d;
            state_q     <= state_d;
            live_q      <= live_d;
            row_done_q  <= row_done_d;
            bg_valid_q  <= bg_valid_d;
            bg_data_q   <= bg_data_d;
        end
    end

    bg_fetch_pipe #(
        .DEPTH(MEM_LATENCY)
    ) u_pipe (
        .clk     (clk),
        .rst_n   (reset),
        .shift_in(fire),
        .abort   (abort),
        .pre_o   (pre),
        .cap_o   (cap)
    );

    assign mem.mem_addr = addr_q;
    assign mem.mem_rd   = fire;
    assign bg_data      = bg_data_q;
    assign bg_valid     = bg_valid_q;
    assign row_done     = row_done_q;

endmodule
